// File: rtl/padding_row_sched.sv
// padding_row_sched: row-fetch scheduler for a 3-row sliding window over a padded image.
// Three row slots are filled once per frame. After that, each new window overwrites only
// the oldest slot, and top_slot rotates to mark which slot holds the window's first row.
// Rows are never copied between slots.
// Optional feature: define PAD_ZERO_ROW_EN to generate the two padding rows (0 and IMG_H+1)
// internally. When it is defined, those rows are cleared via zero_row instead of fetched.
module padding_row_sched #(
    parameter int IMG_H = 416,
    parameter int ROW_W = 9
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             row_ack,
    input  logic             conv_done,
    output logic             row_req,
    output logic [ROW_W-1:0] row_idx,
    output logic             load_en,
    output logic [1:0]       load_sel,
    output logic [1:0]       top_slot,
    output logic             window_valid,
    output logic             busy,
    output logic             frame_done
`ifdef PAD_ZERO_ROW_EN
    ,
    output logic             zero_row
`endif
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FILL,
        S_WINDOW,
        S_SLIDE,
        S_DONE
    } state_t;

    localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(IMG_H + 1);
    localparam logic [ROW_W-1:0] LAST_WIN = ROW_W'(IMG_H - 1);

    state_t           state_q, state_d;
    logic [ROW_W-1:0] row_idx_q, row_idx_d;
    logic [1:0]       fill_cnt_q, fill_cnt_d;
    logic [ROW_W-1:0] win_cnt_q, win_cnt_d;
    logic [1:0]       top_slot_q, top_slot_d;
    logic             pad_row;

`ifdef PAD_ZERO_ROW_EN
    // Padding rows are synthesised locally, so they never go through the handshake.
    assign pad_row  = (row_idx_q == '0) || (row_idx_q == LAST_ROW);
    assign zero_row = load_en & pad_row;
`else
    assign pad_row  = 1'b0;
`endif

    assign row_idx  = row_idx_q;
    assign top_slot = top_slot_q;

    // Next-state, counter updates and handshake outputs; defaults assigned first.
    always_comb begin
        state_d      = state_q;
        row_idx_d    = row_idx_q;
        fill_cnt_d   = fill_cnt_q;
        win_cnt_d    = win_cnt_q;
        top_slot_d   = top_slot_q;
        row_req      = 1'b0;
        load_en      = 1'b0;
        load_sel     = 2'd0;
        window_valid = 1'b0;
        frame_done   = 1'b0;
        busy         = (state_q != S_IDLE);

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d    = S_FILL;
                    row_idx_d  = '0;
                    fill_cnt_d = 2'd0;
                    win_cnt_d  = '0;
                    top_slot_d = 2'd0;
                end
            end

            S_FILL: begin
                row_req  = ~pad_row;
                load_sel = fill_cnt_q;
                if (pad_row || row_ack) begin
                    load_en    = 1'b1;
                    row_idx_d  = row_idx_q + 1'b1;
                    fill_cnt_d = fill_cnt_q + 2'd1;
                    if (fill_cnt_q == 2'd2) begin
                        state_d = S_WINDOW;
                    end
                end
            end

            S_WINDOW: begin
                window_valid = 1'b1;
                if (conv_done) begin
                    if (win_cnt_q == LAST_WIN) begin
                        state_d = S_DONE;
                    end else begin
                        win_cnt_d = win_cnt_q + 1'b1;
                        state_d   = S_SLIDE;
                    end
                end
            end

            S_SLIDE: begin
                row_req  = ~pad_row;
                load_sel = top_slot_q;
                if (pad_row || row_ack) begin
                    load_en    = 1'b1;
                    top_slot_d = (top_slot_q == 2'd2) ? 2'd0 : top_slot_q + 2'd1;
                    // The final slide loads the last padded row; the index stays there.
                    if (row_idx_q != LAST_ROW) begin
                        row_idx_d = row_idx_q + 1'b1;
                    end
                    state_d = S_WINDOW;
                end
            end

            S_DONE: begin
                frame_done = 1'b1;
                state_d    = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and counter registers with synchronous reset taking priority over all inputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            row_idx_q  <= '0;
            fill_cnt_q <= 2'd0;
            win_cnt_q  <= '0;
            top_slot_q <= 2'd0;
        end else begin
            state_q    <= state_d;
            row_idx_q  <= row_idx_d;
            fill_cnt_q <= fill_cnt_d;
            win_cnt_q  <= win_cnt_d;
            top_slot_q <= top_slot_d;
        end
    end

endmodule

// File: tb/tb_padding_row_sched.sv
// tb_padding_row_sched: scoreboard bench for padding_row_sched with IMG_H=4.
// Expected loads and windows are queued when a frame is started. A negedge monitor pops
// and compares them as the DUT presents load_en or a new window_valid period.
module tb_padding_row_sched;

    localparam int IMG_H = 4;
    localparam int ROW_W = 9;

    typedef struct {
        int row;
        int sel;
        bit zero;
    } load_t;

    logic             clk;
    logic             reset;
    logic             start;
    logic             row_ack;
    logic             convDone;
    logic             strayConv;
    logic             strayStart;
    logic             row_req;
    logic [ROW_W-1:0] row_idx;
    logic             load_en;
    logic [1:0]       load_sel;
    logic [1:0]       top_slot;
    logic             window_valid;
    logic             busy;
    logic             frame_done;
`ifdef PAD_ZERO_ROW_EN
    logic             zero_row;
`endif

    load_t loadQ[$];
    int    winQ[$];
    load_t expLoad;
    int    expWin;
    int    slotRow[3];
    int    total, bad;
    int    winSeen, doneSeen;
    logic  prevWv;
    bit    ackTied, injectStray;
    int    ackDelay, convDelay, waitCnt, convWait;

    padding_row_sched #(.IMG_H(IMG_H), .ROW_W(ROW_W)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start | strayStart),
        .row_ack     (row_ack),
        .conv_done   (convDone | strayConv),
        .row_req     (row_req),
        .row_idx     (row_idx),
        .load_en     (load_en),
        .load_sel    (load_sel),
        .top_slot    (top_slot),
        .window_valid(window_valid),
        .busy        (busy),
        .frame_done  (frame_done)
`ifdef PAD_ZERO_ROW_EN
        ,
        .zero_row    (zero_row)
`endif
    );

    // Free-running clock, 10 time units per period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Scores one comparison and reports it if the DUT disagrees.
    task automatic checkOutput(input string name, input int actual, input int expected);
        total++;
        if (actual != expected) begin
            bad++;
            $display("[TB] FAIL %s actual=%0d expected=%0d", name, actual, expected);
        end
    endtask

    // Padding-unit model: either acks continuously or answers each request after ackDelay cycles.
    initial begin
        row_ack = 1'b0;
        waitCnt = 0;
        forever begin
            @(posedge clk);
            #1;
            if (ackTied) begin
                row_ack = 1'b1;
            end else if (row_ack) begin
                row_ack = 1'b0;
            end else if (row_req) begin
                if (waitCnt >= ackDelay) begin
                    row_ack = 1'b1;
                    waitCnt = 0;
                end else begin
                    waitCnt++;
                end
            end else begin
                waitCnt = 0;
            end
        end
    end

    // Consumer model: finishes each window convDelay cycles after it appears.
    initial begin
        convDone = 1'b0;
        convWait = 0;
        forever begin
            @(posedge clk);
            #1;
            convDone = 1'b0;
            if (window_valid && !reset) begin
                if (convWait >= convDelay) begin
                    convDone = 1'b1;
                    convWait = 0;
                end else begin
                    convWait++;
                end
            end else begin
                convWait = 0;
            end
        end
    end

    // Disturbance source: conv_done outside WINDOW and start while a window is up.
    initial begin
        strayConv  = 1'b0;
        strayStart = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            strayConv  = injectStray && busy && !window_valid;
            strayStart = injectStray && window_valid;
        end
    end

    // Monitor: pops expected loads and windows and keeps a model of what each slot holds.
    initial begin
        prevWv = 1'b0;
        forever begin
            @(negedge clk);
            if (reset) begin
                prevWv = 1'b0;
            end else begin
                if (row_req && !row_ack) begin
                    checkOutput("noLoadWhileWait", int'(load_en), 0);
                    if (loadQ.size() > 0) checkOutput("holdRowIdx", int'(row_idx), loadQ[0].row);
                end
`ifndef PAD_ZERO_ROW_EN
                if (!row_req) checkOutput("loadWithoutReq", int'(load_en), 0);
`endif
                if (load_en) begin
                    if (loadQ.size() == 0) begin
                        checkOutput("unexpectedLoad", int'(row_idx), -1);
                    end else begin
                        expLoad = loadQ.pop_front();
                        checkOutput("loadRow", int'(row_idx), expLoad.row);
                        checkOutput("loadSel", int'(load_sel), expLoad.sel);
`ifdef PAD_ZERO_ROW_EN
                        checkOutput("zeroRow", int'(zero_row), int'(expLoad.zero));
                        if (expLoad.zero) checkOutput("padRowNoReq", int'(row_req), 0);
`endif
                    end
                    if (load_sel < 2'd3) slotRow[load_sel] = int'(row_idx);
                end
                if (window_valid && !prevWv) begin
                    winSeen++;
                    if (winQ.size() == 0) begin
                        checkOutput("unexpectedWindow", int'(top_slot), -1);
                    end else begin
                        expWin = winQ.pop_front();
                        checkOutput("windowTopSlot", int'(top_slot), expWin % 3);
                        for (int i = 0; i < 3; i++) begin
                            checkOutput($sformatf("window%0dRow%0d", expWin, i),
                                        slotRow[(int'(top_slot) + i) % 3], expWin + i);
                        end
                    end
                end
                if (frame_done) doneSeen++;
                prevWv = window_valid;
            end
        end
    end

    // Checks every output against its reset value.
    task automatic checkResetValues(input string tag);
        checkOutput({tag, "RowReq"}, int'(row_req), 0);
        checkOutput({tag, "RowIdx"}, int'(row_idx), 0);
        checkOutput({tag, "LoadEn"}, int'(load_en), 0);
        checkOutput({tag, "LoadSel"}, int'(load_sel), 0);
        checkOutput({tag, "TopSlot"}, int'(top_slot), 0);
        checkOutput({tag, "WindowValid"}, int'(window_valid), 0);
        checkOutput({tag, "Busy"}, int'(busy), 0);
        checkOutput({tag, "FrameDone"}, int'(frame_done), 0);
    endtask

    // Queues the hand-derived frame: padded row r always lands in slot r mod 3, window k at top k mod 3.
    task automatic queueFrame();
        load_t l;
        for (int r = 0; r < IMG_H + 2; r++) begin
            l.row = r;
            l.sel = r % 3;
`ifdef PAD_ZERO_ROW_EN
            l.zero = (r == 0) || (r == IMG_H + 1);
`else
            l.zero = 1'b0;
`endif
            loadQ.push_back(l);
        end
        for (int k = 0; k < IMG_H; k++) winQ.push_back(k);
    endtask

    // One start pulse sampled at the next rising edge.
    task automatic pulseStart();
        @(posedge clk);
        #1;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Runs one complete frame under the given handshake timing and checks its totals.
    task automatic applyStimulus(input bit tied, input int aDelay, input int cDelay, input bit stray);
        int d0, w0;
        ackTied     = tied;
        ackDelay    = aDelay;
        convDelay   = cDelay;
        injectStray = stray;
        d0 = doneSeen;
        w0 = winSeen;
        queueFrame();
        pulseStart();
        for (int c = 0; c < 1000; c++) begin
            if (doneSeen != d0) break;
            @(posedge clk);
        end
        checkOutput("frameFinished", int'(doneSeen != d0), 1);
        repeat (3) @(posedge clk);
        #1;
        injectStray = 1'b0;
        checkOutput("frameDoneCount", doneSeen - d0, 1);
        checkOutput("windowCount", winSeen - w0, IMG_H);
        checkOutput("loadsLeft", loadQ.size(), 0);
        checkOutput("windowsLeft", winQ.size(), 0);
        checkOutput("idleAfterFrame", int'(busy), 0);
        loadQ.delete();
        winQ.delete();
    endtask

    // Starts a frame, then asserts reset while the DUT waits for row 4 in the slide after window 1.
    task automatic resetMidSlide();
        int w0;
        bit hit;
        ackTied   = 1'b0;
        ackDelay  = 3;
        convDelay = 1;
        w0 = winSeen;
        hit = 1'b0;
        queueFrame();
        pulseStart();
        for (int c = 0; c < 500; c++) begin
            @(negedge clk);
            if ((winSeen - w0) == 2 && row_req && !window_valid) begin
                hit = 1'b1;
                break;
            end
        end
        checkOutput("reachedSlide", int'(hit), 1);
        checkOutput("slideRowIdx", int'(row_idx), 4);
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checkResetValues("midReset");
        reset = 1'b0;
        loadQ.delete();
        winQ.delete();
        for (int i = 0; i < 3; i++) slotRow[i] = -1;
    endtask

    // Hard stop in case a frame never completes.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Top-level sequence of directed scenarios.
    initial begin
        total       = 0;
        bad         = 0;
        winSeen     = 0;
        doneSeen    = 0;
        ackTied     = 1'b0;
        ackDelay    = 0;
        convDelay   = 0;
        injectStray = 1'b0;
        start       = 1'b0;
        reset       = 1'b1;
        for (int i = 0; i < 3; i++) slotRow[i] = -1;

        repeat (3) @(posedge clk);
        @(negedge clk);
        checkResetValues("reset");
        reset = 1'b0;

        $display("[TB] frame with row_ack tied high");
        applyStimulus(1'b1, 0, 0, 1'b0);
        $display("[TB] frame with delayed row_ack");
        applyStimulus(1'b0, 3, 2, 1'b0);
        $display("[TB] frame with stray conv_done and start");
        applyStimulus(1'b0, 1, 1, 1'b1);
        $display("[TB] reset during slide");
        resetMidSlide();
        $display("[TB] frame after reset");
        applyStimulus(1'b1, 0, 0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/padding_row_sched.md
PADDING_ROW_SCHED -- requirements
Module: padding_row_sched

Interface
REQ-001 Parameter IMG_H, 416, unpadded image height in rows; padded height is IMG_H+2, window count is IMG_H.
REQ-002 Parameter ROW_W, 9, width of row_idx.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 start  input  1  frame-start pulse; sampled only in IDLE.
REQ-006 row_ack  input  1  padding unit presents padded row row_idx this cycle.
REQ-007 conv_done  input  1  consumer finished current 3-row window.
REQ-008 row_req  output  1  request for padded row row_idx.
REQ-009 row_idx  output  ROW_W  padded row index requested, 0..IMG_H+1.
REQ-010 load_en  output  1  write strobe to row slot load_sel.
REQ-011 load_sel  output  2  target row slot, 0..2.
REQ-012 top_slot  output  2  slot holding window row 0; rows 1 and 2 are (top_slot+1) mod 3 and (top_slot+2) mod 3.
REQ-013 window_valid  output  1  three slots hold a complete window.
REQ-014 busy  output  1  high in every state except IDLE.
REQ-015 frame_done  output  1  one-cycle pulse after the last window.

Function
REQ-016 FSM states: IDLE, FILL, WINDOW, SLIDE, DONE.
REQ-017 IDLE: start=1 -> FILL with row_idx=0, fill count=0; otherwise stay.
REQ-018 FILL: row_req=1, held until row_ack; on row_req&row_ack: load_en=1 (combinational, same cycle), load_sel=fill count, row_idx+1, fill count+1; after the third load -> WINDOW.
REQ-019 WINDOW: window_valid=1, row_req=0; on conv_done: if window count=IMG_H-1 -> DONE, else -> SLIDE with window count+1.
REQ-020 SLIDE: row_req=1 until row_ack; on transfer: load_en=1, load_sel=top_slot, top_slot <= (top_slot+1) mod 3, row_idx+1, -> WINDOW next cycle.
REQ-021 DONE: frame_done=1 for exactly one cycle, then IDLE.
REQ-022 Rows are never copied between slots; sliding is done solely by top_slot rotation.
REQ-023 Total transfers per frame = IMG_H+2; total windows = IMG_H; row_idx never exceeds IMG_H+1.
REQ-024 row_ack while row_req=0 ignored; conv_done outside WINDOW ignored; start while busy ignored.
REQ-025 Minimum window-to-window gap: 2 cycles (SLIDE with immediate ack, then WINDOW).
REQ-026 load_en=0 whenever row_req=0.

Reset
REQ-027 reset=1 forces IDLE at next edge regardless of state, including mid-handshake.
REQ-028 Reset values: row_req=0, row_idx=0, load_en=0, load_sel=0, top_slot=0, window_valid=0, busy=0, frame_done=0, all counters 0.
REQ-029 reset takes priority over start, row_ack and conv_done in the same cycle.

Configuration
REQ-030 Macro PAD_ZERO_ROW_EN selects internal zero-row generation.
REQ-031 Defined: for row_idx 0 and IMG_H+1 the controller keeps row_req=0, asserts load_en for one cycle without waiting for row_ack, and asserts zero_row (extra 1-bit output, high with that load_en) so the slot is cleared.
REQ-032 Not defined: zero_row port absent; every row, including padding rows, is fetched through the row_req/row_ack handshake.

Verification
REQ-033 IMG_H=4, macro off, row_ack tied 1, start pulse -> 6 transfers row_idx 0..5, load_sel 0,1,2,0,1,2, 4 window_valid periods, frame_done once.
REQ-034 IMG_H=4, row_ack delayed 3 cycles per request -> row_req held steady, row_idx unchanged during wait, load_en only on ack cycle.
REQ-035 conv_done pulsed in FILL and SLIDE, start pulsed in WINDOW -> no state, counter or top_slot change.
REQ-036 reset asserted in SLIDE of window 2 -> next cycle all outputs at reset values; new start restarts at row_idx 0, top_slot 0.
REQ-037 IMG_H=4, PAD_ZERO_ROW_EN defined -> rows 0 and 5 loaded with zero_row=1, no row_req; rows 1..4 via handshake; 4 windows.
REQ-038 Window k (0-based) -> slots top_slot, +1, +2 hold padded rows k, k+1, k+2 (checked by scoreboard).
